// File: rtl/axis_byte_pack_arbiter.sv
// Purpose: grants one byte FIFO per word, packs BPW bytes LSB-first onto AXIS with tdest = source index. Define ARB_PRIO0_EN to give source 0 strict priority.
// Latency: tvalid rises BPW+1 edges after the grant edge. Peak rate is one word per BPW+3 cycles.
// Backpressure: the word is held in VALID while tready=0, and no FIFO is read until the word is accepted.
module axis_byte_pack_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int LOGIC_SIZE = 32
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_reset_n,
    input  logic [NUM_SRC-1:0]         i_empty,
    output logic [NUM_SRC-1:0]         o_rd_req,
    input  logic [NUM_SRC*8-1:0]       i_data,
    output logic [LOGIC_SIZE-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(NUM_SRC)-1:0] m_axis_tdest
);
    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int BPW   = LOGIC_SIZE / 8;
    localparam int CNT_W = $clog2(BPW) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

`ifdef ARB_PRIO0_EN
    // Source 0 sits outside the rotation, so the pointer lives in 1..NUM_SRC-1.
    localparam logic [SRC_W-1:0] RR_RST = SRC_W'(1);
`else
    localparam logic [SRC_W-1:0] RR_RST = '0;
`endif

    logic [1:0]       state;
    logic [SRC_W-1:0] grant;
    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] rr_nxt;
    logic [SRC_W-1:0] arb_idx;
    logic [SRC_W-1:0] cand;
    logic             arb_hit;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] captured;
    logic             rd_q;
    logic             fetch_rd;
    logic [7:0]       rd_byte;

    // Read request for the granted source; reset forces it low in the same cycle.
    always_comb begin
        fetch_rd = s_axis_reset_n && (state == ST_FETCH) && !i_empty[grant]
                   && (issued < CNT_W'(BPW));
        o_rd_req        = '0;
        o_rd_req[grant] = fetch_rd;
        rd_byte         = i_data[{grant, 3'b000} +: 8];
    end

    // Arbitration: first non-empty source, starting the search at rr_ptr.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
`ifdef ARB_PRIO0_EN
        if (!i_empty[0]) begin
            arb_hit = 1'b1;
        end
        for (int i = 0; i < NUM_SRC - 1; i++) begin
            cand = SRC_W'(1 + ((int'(rr_ptr) - 1 + i) % (NUM_SRC - 1)));
            if (!arb_hit && !i_empty[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
`else
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = SRC_W'((int'(rr_ptr) + i) % NUM_SRC);
            if (!arb_hit && !i_empty[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
`endif
    end

    // Next pointer once the current word is accepted: the source after the one just served.
    always_comb begin
        rr_nxt = rr_ptr;
`ifdef ARB_PRIO0_EN
        if (grant != '0) begin
            rr_nxt = (int'(grant) == NUM_SRC - 1) ? SRC_W'(1) : grant + 1'b1;
        end
`else
        rr_nxt = (int'(grant) == NUM_SRC - 1) ? '0 : grant + 1'b1;
`endif
    end

    // FSM: grant, fetch and pack BPW bytes, then hold the word until it is accepted.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_reset_n) begin
            state         <= ST_IDLE;
            grant         <= '0;
            rr_ptr        <= RR_RST;
            issued        <= '0;
            captured      <= '0;
            rd_q          <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdest  <= '0;
        end else begin
            rd_q <= fetch_rd;
            case (state)
                ST_IDLE: begin
                    if (arb_hit) begin
                        grant    <= arb_idx;
                        issued   <= '0;
                        captured <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_rd) begin
                        issued <= issued + 1'b1;
                    end
                    // FIFO dout is valid the cycle after the request.
                    if (rd_q) begin
                        for (int n = 0; n < BPW; n++) begin
                            if (captured == CNT_W'(n)) begin
                                m_axis_tdata[8*n +: 8] <= rd_byte;
                            end
                        end
                        captured <= captured + 1'b1;
                        if (captured == CNT_W'(BPW - 1)) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdest  <= grant;
                            state         <= ST_VALID;
                        end
                    end
                end
                ST_VALID: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        rr_ptr        <= rr_nxt;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_byte_pack_arbiter.sv
// Directed bench for axis_byte_pack_arbiter with NUM_SRC=2 and LOGIC_SIZE=32.
// Byte FIFOs are modelled as arrays, and accepted words are recorded at each tvalid&&tready edge.
// Every scenario task does its own inline comparisons.
module tb_axis_byte_pack_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  i_empty;
    logic [1:0]  o_rd_req;
    logic [15:0] i_data;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [0:0]  tdest;

    logic [7:0]  mem [2][256];
    logic [7:0]  wr_ptr [2];
    logic [7:0]  rd_ptr [2] = '{8'd0, 8'd0};
    int          rd_cnt [2] = '{0, 0};
    int          cyc = 0;
    logic [31:0] wq_data [$];
    int          wq_dest [$];
    int          wq_cyc  [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    axis_byte_pack_arbiter #(.NUM_SRC(2), .LOGIC_SIZE(32)) dut (
        .s_axis_aclk    (clk),
        .s_axis_reset_n (rst_n),
        .i_empty        (i_empty),
        .o_rd_req       (o_rd_req),
        .i_data         (i_data),
        .m_axis_tdata   (tdata),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tdest   (tdest)
    );

    assign i_empty = {wr_ptr[1] == rd_ptr[1], wr_ptr[0] == rd_ptr[0]};

    // FIFO read side and output word recorder.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (o_rd_req[k]) begin
                i_data[8*k +: 8] <= mem[k][rd_ptr[k]];
                rd_ptr[k]        <= rd_ptr[k] + 8'd1;
                rd_cnt[k]        <= rd_cnt[k] + 1;
            end
        end
        if (tvalid && tready) begin
            wq_data.push_back(tdata);
            wq_dest.push_back(int'(tdest));
            wq_cyc.push_back(cyc);
        end
    end

    task automatic push(input int k, input logic [7:0] b);
        mem[k][wr_ptr[k]] = b;
        wr_ptr[k] = wr_ptr[k] + 8'd1;
    endtask

    task automatic clear_words();
        wq_data.delete();
        wq_dest.delete();
        wq_cyc.delete();
    endtask

    task automatic wait_words(input int n, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (wq_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 8'h10 + 8'(i));
            push(1, 8'h20 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (o_rd_req !== 2'b00) begin errors++; $display("FAIL reset_rd_req cyc%0d got %b exp 00", i, o_rd_req); end
            checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid cyc%0d got %b exp 0", i, tvalid); end
            checks++; if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata cyc%0d got %h exp 0", i, tdata); end
            checks++; if (tdest !== 1'b0) begin errors++; $display("FAIL reset_tdest cyc%0d got %b exp 0", i, tdest); end
        end
        checks++; if (rd_cnt[0] + rd_cnt[1] != 0) begin errors++; $display("FAIL reset_pops got %0d exp 0", rd_cnt[0] + rd_cnt[1]); end
        wr_ptr[0] = rd_ptr[0];
        wr_ptr[1] = rd_ptr[1];
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_data [4];
        int          exp_dest [4];
        bit          ok;
`ifdef ARB_PRIO0_EN
        exp_data = '{32'hA3A2A1A0, 32'hA7A6A5A4, 32'hB3B2B1B0, 32'hB7B6B5B4};
        exp_dest = '{0, 0, 1, 1};
`else
        exp_data = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hA7A6A5A4, 32'hB7B6B5B4};
        exp_dest = '{0, 1, 0, 1};
`endif
        clear_words();
        tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(0, 8'hA0 + 8'(i));
            push(1, 8'hB0 + 8'(i));
        end
        wait_words(4, 150, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got %0d words exp 4", wq_data.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wq_data.size()) begin
                checks++; if (wq_data[i] !== exp_data[i]) begin errors++; $display("FAIL rr_data%0d got %h exp %h", i, wq_data[i], exp_data[i]); end
                checks++; if (wq_dest[i] != exp_dest[i]) begin errors++; $display("FAIL rr_dest%0d got %0d exp %0d", i, wq_dest[i], exp_dest[i]); end
            end
        end
        if (wq_cyc.size() >= 2) begin
            checks++; if (wq_cyc[1] - wq_cyc[0] != 7) begin errors++; $display("FAIL rr_word_period got %0d exp 7", wq_cyc[1] - wq_cyc[0]); end
        end
    endtask

    task automatic test_single_word();
        int rc;
        int lat;
        clear_words();
        tready = 1'b1;
        rc = rd_cnt[0];
        push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h44);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tvalid === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL single_latency got %0d exp 6", lat); end
        checks++; if (tdata !== 32'h44332211) begin errors++; $display("FAIL single_tdata got %h exp 44332211", tdata); end
        checks++; if (tdest !== 1'b0) begin errors++; $display("FAIL single_tdest got %b exp 0", tdest); end
        @(negedge clk);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL single_tvalid_drop got %b exp 0", tvalid); end
        checks++; if (wq_data.size() != 1) begin errors++; $display("FAIL single_word_count got %0d exp 1", wq_data.size()); end
        checks++; if (rd_cnt[0] - rc != 4) begin errors++; $display("FAIL single_rd_pulses got %0d exp 4", rd_cnt[0] - rc); end
    endtask

    task automatic test_underflow_stall();
        int  r0;
        int  r1;
        bit  ok;
        clear_words();
        tready = 1'b1;
        r0 = rd_cnt[0];
        r1 = rd_cnt[1];
        push(1, 8'h55); push(1, 8'h66);
        repeat (2) @(negedge clk);
        push(0, 8'hC0); push(0, 8'hC1); push(0, 8'hC2); push(0, 8'hC3);
        repeat (10) @(negedge clk);
        checks++; if (rd_cnt[0] != r0) begin errors++; $display("FAIL stall_src0_reads got %0d exp 0", rd_cnt[0] - r0); end
        checks++; if (rd_cnt[1] - r1 != 2) begin errors++; $display("FAIL stall_src1_reads got %0d exp 2", rd_cnt[1] - r1); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL stall_tvalid got %b exp 0", tvalid); end
        push(1, 8'h77); push(1, 8'h88);
        wait_words(2, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got %0d words exp 2", wq_data.size()); end
        if (wq_data.size() >= 2) begin
            checks++; if (wq_data[0] !== 32'h88776655) begin errors++; $display("FAIL stall_data0 got %h exp 88776655", wq_data[0]); end
            checks++; if (wq_dest[0] != 1) begin errors++; $display("FAIL stall_dest0 got %0d exp 1", wq_dest[0]); end
            checks++; if (wq_data[1] !== 32'hC3C2C1C0) begin errors++; $display("FAIL stall_data1 got %h exp c3c2c1c0", wq_data[1]); end
            checks++; if (wq_dest[1] != 0) begin errors++; $display("FAIL stall_dest1 got %0d exp 0", wq_dest[1]); end
        end
        checks++; if (rd_cnt[0] - r0 != 4) begin errors++; $display("FAIL stall_src0_total got %0d exp 4", rd_cnt[0] - r0); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_words();
        tready = 1'b0;
        push(1, 8'hE0); push(1, 8'hE1); push(1, 8'hE2); push(1, 8'hE3);
        repeat (2) @(negedge clk);
        push(0, 8'hD0); push(0, 8'hD1); push(0, 8'hD2); push(0, 8'hD3);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_tvalid_timeout got 0 exp 1"); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid cyc%0d got %b exp 1", i, tvalid); end
            checks++; if (tdata !== 32'hE3E2E1E0) begin errors++; $display("FAIL bp_tdata cyc%0d got %h exp e3e2e1e0", i, tdata); end
            checks++; if (tdest !== 1'b1) begin errors++; $display("FAIL bp_tdest cyc%0d got %b exp 1", i, tdest); end
            checks++; if (o_rd_req !== 2'b00) begin errors++; $display("FAIL bp_rd_req cyc%0d got %b exp 00", i, o_rd_req); end
            @(negedge clk);
        end
        tready = 1'b1;
        @(negedge clk);
        checks++; if (wq_data.size() != 1) begin errors++; $display("FAIL bp_accept_count got %0d exp 1", wq_data.size()); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_tvalid_after got %b exp 0", tvalid); end
        wait_words(2, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got %0d words exp 2", wq_data.size()); end
        if (wq_data.size() >= 2) begin
            checks++; if (wq_data[0] !== 32'hE3E2E1E0) begin errors++; $display("FAIL bp_data0 got %h exp e3e2e1e0", wq_data[0]); end
            checks++; if (wq_data[1] !== 32'hD3D2D1D0 || wq_dest[1] != 0) begin errors++; $display("FAIL bp_word1 got %h/%0d exp d3d2d1d0/0", wq_data[1], wq_dest[1]); end
        end
    endtask

    task automatic test_reset_mid_word();
        bit ok;
        clear_words();
        tready = 1'b1;
        push(1, 8'h90); push(1, 8'h91); push(1, 8'h92); push(1, 8'h93);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_rd_req !== 2'b00 || tvalid !== 1'b0) begin errors++; $display("FAIL midrst_outputs got %b/%b exp 00/0", o_rd_req, tvalid); end
        wr_ptr[0] = rd_ptr[0];
        wr_ptr[1] = rd_ptr[1];
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        checks++; if (wq_data.size() != 0) begin errors++; $display("FAIL midrst_no_word got %0d exp 0", wq_data.size()); end
        push(0, 8'hF0); push(0, 8'hF1); push(0, 8'hF2); push(0, 8'hF3);
        wait_words(1, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_timeout got 0 words exp 1"); end
        if (wq_data.size() >= 1) begin
            checks++; if (wq_data[0] !== 32'hF3F2F1F0 || wq_dest[0] != 0) begin errors++; $display("FAIL midrst_word got %h/%0d exp f3f2f1f0/0", wq_data[0], wq_dest[0]); end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        tready    = 1'b0;
        wr_ptr[0] = 8'd0;
        wr_ptr[1] = 8'd0;
        test_reset();
        test_round_robin();
        test_single_word();
        test_underflow_stall();
        test_backpressure();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
